// File: rtl/task_sequencer.sv
// rtl/task_sequencer.sv - experiment scheduler: optional SPI config pass, then N task runs with idle gaps
// Optional per-step watchdog enabled by defining SEQ_WATCHDOG_EN.
module task_sequencer #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 32,
  parameter int TO_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_en_config,
  input  logic [CNT_W-1:0] cfg_nrun,
  input  logic [GAP_W-1:0] cfg_tgap,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             done_spi,
  input  logic             done_task,
  output logic             trigger_config,
  output logic             trigger_task,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] run_cnt,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CFG  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             trig_cfg_q, trig_cfg_d;
  logic             trig_task_q, trig_task_d;
  logic             rearm_q, rearm_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] nrun_q;
  logic [GAP_W-1:0] tgap_q;
  logic             done_spi_q, done_task_q;

  logic             rise_spi, rise_task, accept;
  logic [CNT_W-1:0] run_next;

  assign rise_spi  = done_spi & ~done_spi_q;
  assign rise_task = done_task & ~done_task_q;
  assign accept    = (state_q == S_IDLE) && start && !abort;
  assign run_next  = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CNT_W'(1);

`ifdef SEQ_WATCHDOG_EN
  logic [TO_W-1:0] tout_q, wd_q, wd_d;
  logic            wd_expire;

  assign wd_expire = (tout_q != '0) && ((wd_q + TO_W'(1)) == tout_q);

  // Counter restarts on every CFG/RUN entry, including a zero-gap RUN re-entry.
  always_comb begin
    wd_d = '0;
    if ((state_d == S_CFG || state_d == S_RUN) && state_d == state_q && !rearm_d)
      wd_d = wd_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tout_q <= '0;
      wd_q   <= '0;
    end else begin
      wd_q <= wd_d;
      if (accept) tout_q <= cfg_timeout;
    end
  end
`else
  logic wd_expire;
  logic unused_timeout;
  assign wd_expire      = 1'b0;
  assign unused_timeout = ^cfg_timeout;
`endif

  always_comb begin
    state_d     = state_q;
    trig_cfg_d  = 1'b0;
    trig_task_d = 1'b0;
    rearm_d     = 1'b0;
    error_d     = error_q;
    run_cnt_d   = run_cnt_q;
    gap_d       = gap_q;
    case (state_q)
      S_IDLE: if (accept) begin
        error_d   = 1'b0;
        run_cnt_d = '0;
        if (cfg_en_config) begin
          state_d    = S_CFG;
          trig_cfg_d = 1'b1;
        end else if (cfg_nrun != '0) begin
          state_d     = S_RUN;
          trig_task_d = 1'b1;
        end else begin
          state_d = S_FIN;
        end
      end
      S_CFG: begin
        if (abort) state_d = S_IDLE;
        else if (rise_spi) begin
          if (nrun_q != '0) begin
            state_d     = S_RUN;
            trig_task_d = 1'b1;
          end else begin
            state_d = S_FIN;
          end
        end else if (wd_expire) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) state_d = S_IDLE;
        else if (rise_task) begin
          run_cnt_d = run_next;
          if (run_next == nrun_q) state_d = S_FIN;
          else if (tgap_q != '0) begin
            state_d = S_GAP;
            gap_d   = tgap_q - GAP_W'(1);
          end else begin
            rearm_d = 1'b1;
          end
        end else if (wd_expire) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          trig_task_d = rearm_q;
        end
      end
      S_GAP: begin
        if (abort) state_d = S_IDLE;
        else if (gap_q == '0) begin
          state_d     = S_RUN;
          trig_task_d = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      trig_cfg_q  <= 1'b0;
      trig_task_q <= 1'b0;
      rearm_q     <= 1'b0;
      error_q     <= 1'b0;
      run_cnt_q   <= '0;
      gap_q       <= '0;
      nrun_q      <= '0;
      tgap_q      <= '0;
      done_spi_q  <= 1'b0;
      done_task_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_cfg_q  <= trig_cfg_d;
      trig_task_q <= trig_task_d;
      rearm_q     <= rearm_d;
      error_q     <= error_d;
      run_cnt_q   <= run_cnt_d;
      gap_q       <= gap_d;
      done_spi_q  <= done_spi;
      done_task_q <= done_task;
      if (accept) begin
        nrun_q <= cfg_nrun;
        tgap_q <= cfg_tgap;
      end
    end
  end

  // An abort arriving in FIN suppresses the completion pulse.
  assign done           = (state_q == S_FIN) && !abort;
  assign busy           = (state_q != S_IDLE);
  assign trigger_config = trig_cfg_q;
  assign trigger_task   = trig_task_q;
  assign error          = error_q;
  assign run_cnt        = run_cnt_q;
  assign state          = state_q;

endmodule

// File: tb/tb_task_sequencer.sv
// tb/tb_task_sequencer.sv - scoreboard bench for task_sequencer
// Watchdog expectations follow SEQ_WATCHDOG_EN.
module tb_task_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cfg_en_config = 1'b0;
  logic [15:0] cfg_nrun = '0;
  logic [31:0] cfg_tgap = '0;
  logic [31:0] cfg_timeout = '0;
  logic        done_spi = 1'b0;
  logic        done_task = 1'b0;
  logic        trigger_config, trigger_task, busy, done, error;
  logic [15:0] run_cnt;
  logic [2:0]  state;

  task_sequencer #(.CNT_W(16), .GAP_W(32), .TO_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_en_config(cfg_en_config), .cfg_nrun(cfg_nrun), .cfg_tgap(cfg_tgap),
    .cfg_timeout(cfg_timeout), .done_spi(done_spi), .done_task(done_task),
    .trigger_config(trigger_config), .trigger_task(trigger_task), .busy(busy),
    .done(done), .error(error), .run_cnt(run_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] at;
    logic [15:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  gap_seen = 1'b0;
  int  delay = 10;
  int  task_hold = 1;
  bit  resp_task_en = 1'b1;
  int  spi_at = -1;
  int  task_at = -1;
  int  task_off = -1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int at, input int cnt);
    ev_t e;
    e.kind = 2'(kind);
    e.at   = 32'(at);
    e.cnt  = 16'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic start_seq(input bit en, input int nrun, input int tgap, input int tout);
    cfg_en_config = en;
    cfg_nrun      = 16'(nrun);
    cfg_tgap      = 32'(tgap);
    cfg_timeout   = 32'(tout);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every trigger/done pulse is matched against the head of the queue.
  initial forever begin
    ev_t e;
    int  kind;
    @(negedge clk);
    if (state == 3'd3) gap_seen = 1'b1;
    if (trigger_config || trigger_task || done) begin
      kind = done ? 2 : (trigger_task ? 1 : 0);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: actual kind=%0d cyc=%0d run_cnt=%0d required no event",
                 kind, cyc, run_cnt);
      end else begin
        e = exp_q.pop_front();
        if (kind != int'(e.kind) || cyc != int'(e.at) || run_cnt != e.cnt) begin
          n_bad++;
          $display("FAIL event: actual kind=%0d cyc=%0d run_cnt=%0d required kind=%0d cyc=%0d run_cnt=%0d",
                   kind, cyc, run_cnt, e.kind, e.at, e.cnt);
        end
      end
    end
  end

  // Responder: done pulses returned a fixed delay after each trigger.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      spi_at = -1; task_at = -1; task_off = -1;
      done_spi = 1'b0; done_task = 1'b0;
    end else begin
      if (done_spi) done_spi = 1'b0;
      if (cyc == spi_at) done_spi = 1'b1;
      if (cyc == task_off) done_task = 1'b0;
      if (cyc == task_at) begin
        done_task = 1'b1;
        task_off  = cyc + task_hold;
      end
      if (trigger_config) spi_at = cyc + delay;
      if (trigger_task && resp_task_en) task_at = cyc + delay;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int s;
    repeat (2) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_busy", busy, 0);
    chk("reset_run_cnt", run_cnt, 0);
    chk("reset_error", error, 0);
    chk("reset_trig", {trigger_config, trigger_task, done}, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Normal sequence: config, 3 runs, gap 4
    s = cyc;
    push(0, s + 1, 0); push(1, s + 12, 0); push(1, s + 27, 1); push(1, s + 42, 2); push(2, s + 53, 3);
    start_seq(1'b1, 3, 4, 0);
    wait_until(s + 53);
    chk("normal_busy_at_done", busy, 1);
    wait_until(s + 54);
    chk("normal_busy_after", busy, 0);
    chk("normal_state_after", state, 0);
    chk("normal_run_cnt", run_cnt, 3);
    chk("normal_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    // Zero gap
    s = cyc;
    gap_seen = 1'b0;
    push(1, s + 1, 0); push(1, s + 13, 1); push(2, s + 24, 2);
    start_seq(1'b0, 2, 0, 0);
    wait_until(s + 26);
    chk("zerogap_no_gap", gap_seen, 0);
    chk("zerogap_run_cnt", run_cnt, 2);
    chk("zerogap_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    // Empty run
    s = cyc;
    push(2, s + 1, 0);
    start_seq(1'b0, 0, 0, 0);
    chk("empty_state_fin", state, 4);
    wait_until(s + 2);
    chk("empty_state_idle", state, 0);
    chk("empty_run_cnt", run_cnt, 0);
    wait_until(s + 20);
    chk("empty_queue_empty", exp_q.size(), 0);

    // Abort in GAP with done_task held high
    s = cyc;
    task_hold = 50;
    push(1, s + 1, 0);
    start_seq(1'b0, 3, 8, 0);
    wait_until(s + 14);
    chk("abort_in_gap", state, 3);
    abort = 1'b1;
    wait_until(s + 15);
    abort = 1'b0;
    chk("abort_state", state, 0);
    chk("abort_busy", busy, 0);
    chk("abort_run_cnt", run_cnt, 1);
    wait_until(s + 70);
    chk("abort_run_cnt_hold", run_cnt, 1);
    chk("abort_queue_empty", exp_q.size(), 0);
    task_hold = 1;

    // Watchdog: done_task never returned
    s = cyc;
    resp_task_en = 1'b0;
    push(1, s + 1, 0);
    start_seq(1'b0, 1, 0, 20);
`ifdef SEQ_WATCHDOG_EN
    wait_until(s + 20);
    chk("wd_still_run", state, 2);
    wait_until(s + 21);
    chk("wd_err_state", state, 5);
    chk("wd_error_set", error, 1);
    wait_until(s + 22);
    chk("wd_idle", state, 0);
    chk("wd_error_sticky", error, 1);
`else
    wait_until(s + 40);
    chk("wd_off_run", state, 2);
    chk("wd_off_error", error, 0);
    abort = 1'b1;
    wait_until(s + 41);
    abort = 1'b0;
    chk("wd_off_abort", state, 0);
`endif
    resp_task_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("wd_queue_empty", exp_q.size(), 0);

    // Reset mid-sequence, then a clean rerun
    s = cyc;
    push(0, s + 1, 0); push(1, s + 12, 0);
    start_seq(1'b1, 2, 2, 0);
    chk("rerun_error_cleared", error, 0);
    wait_until(s + 12);
    chk("rst_pre_trig", trigger_task, 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_trig", trigger_task, 0);
    chk("rst_async_state", state, 0);
    chk("rst_async_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    s = cyc;
    push(0, s + 1, 0); push(1, s + 12, 0); push(1, s + 25, 1); push(2, s + 36, 2);
    start_seq(1'b1, 2, 2, 0);
    wait_until(s + 37);
    chk("rerun_busy", busy, 0);
    chk("rerun_run_cnt", run_cnt, 2);
    chk("rerun_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
